weight_tile_sequencer: RTL and testbench

- Parametrised successor of the systolic-array weight controller.
- Sequences weight tiles from the weight FIFO into an N-deep per-PE weight buffer (NUM_BUF ≥ 2), one array row per accepted FIFO word.
- Tracks buffer occupancy against the compute side's tile consumption, and signals the instruction queue when a MAC job's tiles are exhausted.
- Sits between the instruction decoder / weight FIFO and the MAC array.

---
 rtl/weight_tile_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_weight_tile_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_tile_sequencer.sv
// Weight tile sequencer: streams weight FIFO rows into a NUM_BUF-deep per-PE buffer and
// tracks tile occupancy against compute consumption. Optional macro WTS_CHAIN_EN chains jobs.
module weight_tile_sequencer #(
    parameter int unsigned MUL_SIZE = 32,
    parameter int unsigned NUM_BUF  = 2,
    parameter int unsigned DIM_W    = 8,
    parameter int unsigned TILE_W   = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         instr_valid_i,
    input  logic                         instr_load_i,
    input  logic [DIM_W-1:0]             instr_u_dim_i,
    input  logic [DIM_W-1:0]             instr_iter_dim_i,
    output logic                         instr_ack_o,
    input  logic                         fifo_valid_i,
    output logic                         fifo_pop_o,
    output logic [MUL_SIZE-1:0]          load_row_o,
    output logic [$clog2(NUM_BUF)-1:0]   load_buf_sel_o,
    input  logic                         tile_consume_i,
    output logic                         compute_rdy_o,
    output logic [$clog2(NUM_BUF)-1:0]   compute_buf_sel_o,
    output logic [$clog2(NUM_BUF+1)-1:0] occupancy_o,
    output logic                         done_o,
    output logic                         busy_o
);

    localparam int unsigned PTR_W = $clog2(NUM_BUF);
    localparam int unsigned OCC_W = $clog2(NUM_BUF + 1);
    localparam int unsigned ROW_W = $clog2(MUL_SIZE);
    localparam int unsigned PROD_W = 2 * DIM_W + 2;

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_BUF - 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(NUM_BUF);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MUL_SIZE - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StFull, StDrain} state_e;

    state_e              state_q, state_d;
    logic [ROW_W-1:0]    row_cnt_q, row_cnt_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]    occ_q, occ_d;
    logic [TILE_W-1:0]   max_tiles_q, max_tiles_d;
    logic [TILE_W-1:0]   tiles_loaded_q, tiles_loaded_d;
    logic [TILE_W-1:0]   tiles_consumed_q, tiles_consumed_d;
    logic [MUL_SIZE-1:0] load_row_q, load_row_d;
    logic [PTR_W-1:0]    load_buf_sel_q, load_buf_sel_d;

    logic [DIM_W:0]      u_tiles, iter_tiles;
    logic [PROD_W-1:0]   tile_prod;
    logic [TILE_W-1:0]   new_max;
    logic                pop, tile_done, consume_acc;
    logic                idle_ack, chain_ack, old_consume, new_consume;
    logic                old_done, job_done, zero_done;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Partial tiles round up in both dimensions.
    always_comb begin
        u_tiles    = ((DIM_W+1)'(instr_u_dim_i) + (DIM_W+1)'(MUL_SIZE - 1)) >> ROW_W;
        iter_tiles = ((DIM_W+1)'(instr_iter_dim_i) + (DIM_W+1)'(MUL_SIZE - 1)) >> ROW_W;
        tile_prod  = PROD_W'(u_tiles) * PROD_W'(iter_tiles);
        new_max    = TILE_W'(tile_prod);
    end

    assign pop         = (state_q == StLoad) & fifo_valid_i & (occ_q != FULL_OCC);
    assign tile_done   = pop & (row_cnt_q == LAST_ROW);
    assign consume_acc = tile_consume_i & (occ_q != '0);
    assign idle_ack    = (state_q == StIdle) & instr_valid_i & instr_load_i;

`ifdef WTS_CHAIN_EN
    logic [TILE_W-1:0] rem_old_q, rem_old_d;

    // Chaining is refused while an older job is still outstanding so every job gets one done.
    assign chain_ack   = (state_q == StDrain) & instr_valid_i & instr_load_i &
                         (new_max != '0) & (rem_old_q == '0);
    assign old_consume = consume_acc & (rem_old_q != '0);
    assign old_done    = old_consume & (rem_old_q == TILE_W'(1));
`else
    assign chain_ack   = 1'b0;
    assign old_consume = 1'b0;
    assign old_done    = 1'b0;
`endif

    assign new_consume = consume_acc & ~old_consume;
    assign job_done    = new_consume & (state_q == StDrain) &
                         ((tiles_consumed_q + TILE_W'(1)) == max_tiles_q);
    assign zero_done   = idle_ack & (new_max == '0);

    always_comb begin
        state_d          = state_q;
        row_cnt_d        = row_cnt_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        occ_d            = occ_q;
        max_tiles_d      = max_tiles_q;
        tiles_loaded_d   = tiles_loaded_q;
        tiles_consumed_d = tiles_consumed_q;
        load_row_d       = '0;
        load_buf_sel_d   = load_buf_sel_q;
`ifdef WTS_CHAIN_EN
        rem_old_d        = rem_old_q - TILE_W'(old_consume);
`endif

        if (pop) begin
            row_cnt_d      = tile_done ? '0 : row_cnt_q + ROW_W'(1);
            load_row_d     = MUL_SIZE'(1) << (LAST_ROW - row_cnt_q);
            load_buf_sel_d = wr_ptr_q;
        end
        if (tile_done) begin
            wr_ptr_d       = next_ptr(wr_ptr_q);
            tiles_loaded_d = tiles_loaded_q + TILE_W'(1);
        end
        if (consume_acc) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        if (new_consume) begin
            tiles_consumed_d = tiles_consumed_q + TILE_W'(1);
        end

        case ({tile_done, consume_acc})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        unique case (state_q)
            StIdle: begin
                if (idle_ack) begin
                    max_tiles_d      = new_max;
                    tiles_loaded_d   = '0;
                    tiles_consumed_d = '0;
                    row_cnt_d        = '0;
                    if (new_max != '0) begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                if (tiles_loaded_d == max_tiles_q) begin
                    state_d = StDrain;
                end else if (occ_d == FULL_OCC) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                if (consume_acc) begin
                    state_d = StLoad;
                end
            end
            StDrain: begin
                if (job_done) begin
                    state_d = StIdle;
                end
`ifdef WTS_CHAIN_EN
                if (chain_ack) begin
                    max_tiles_d      = new_max;
                    rem_old_d        = max_tiles_q - tiles_consumed_q - TILE_W'(new_consume);
                    tiles_loaded_d   = '0;
                    tiles_consumed_d = '0;
                    row_cnt_d        = '0;
                    state_d          = StLoad;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= StIdle;
            row_cnt_q        <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            occ_q            <= '0;
            max_tiles_q      <= '0;
            tiles_loaded_q   <= '0;
            tiles_consumed_q <= '0;
            load_row_q       <= '0;
            load_buf_sel_q   <= '0;
`ifdef WTS_CHAIN_EN
            rem_old_q        <= '0;
`endif
        end else begin
            state_q          <= state_d;
            row_cnt_q        <= row_cnt_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            occ_q            <= occ_d;
            max_tiles_q      <= max_tiles_d;
            tiles_loaded_q   <= tiles_loaded_d;
            tiles_consumed_q <= tiles_consumed_d;
            load_row_q       <= load_row_d;
            load_buf_sel_q   <= load_buf_sel_d;
`ifdef WTS_CHAIN_EN
            rem_old_q        <= rem_old_d;
`endif
        end
    end

    // Input-dependent pulses are forced low while reset is held.
    assign instr_ack_o       = (idle_ack | chain_ack) & ~rst_i;
    assign done_o            = (old_done | job_done | zero_done) & ~rst_i;
    assign fifo_pop_o        = pop;
    assign load_row_o        = load_row_q;
    assign load_buf_sel_o    = load_buf_sel_q;
    assign compute_rdy_o     = (occ_q != '0);
    assign compute_buf_sel_o = rd_ptr_q;
    assign occupancy_o       = occ_q;
    assign busy_o            = (state_q != StIdle);

    occ_bound_a: assert property (@(posedge clk_i) disable iff (rst_i) occ_q <= FULL_OCC);
    order_a: assert property (@(posedge clk_i) disable iff (rst_i)
        (tiles_consumed_q <= tiles_loaded_q) && (tiles_loaded_q <= max_tiles_q));
    strobe_a: assert property (@(posedge clk_i) disable iff (rst_i)
        (load_row_q != '0) |-> $past(pop));

endmodule

// File: tb/tb_weight_tile_sequencer.sv
// Directed bench for weight_tile_sequencer (MUL_SIZE=32, NUM_BUF=2); chain case under WTS_CHAIN_EN.
module tb_weight_tile_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0, instr_load = 1'b0;
    logic [7:0]  u_dim = '0, iter_dim = '0;
    logic        instr_ack, fifo_valid = 1'b0, fifo_pop, consume = 1'b0;
    logic [31:0] load_row;
    logic        load_buf_sel, compute_rdy, compute_buf_sel, done, busy;
    logic [1:0]  occupancy;

    int total = 0, bad = 0;
    int pop_cnt = 0, ack_cnt = 0, done_cnt = 0, strobe_err = 0, popv_err = 0, row_m = 0;
    logic [31:0] pend = '0;
    int base, done_base;
    logic got_done;

    weight_tile_sequencer dut (
        .clk_i(clk), .rst_i(rst),
        .instr_valid_i(instr_valid), .instr_load_i(instr_load),
        .instr_u_dim_i(u_dim), .instr_iter_dim_i(iter_dim), .instr_ack_o(instr_ack),
        .fifo_valid_i(fifo_valid), .fifo_pop_o(fifo_pop),
        .load_row_o(load_row), .load_buf_sel_o(load_buf_sel),
        .tile_consume_i(consume), .compute_rdy_o(compute_rdy),
        .compute_buf_sel_o(compute_buf_sel), .occupancy_o(occupancy),
        .done_o(done), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] u, input logic [7:0] it, input string tag);
        instr_valid = 1'b1; instr_load = 1'b1; u_dim = u; iter_dim = it;
        #1 check(tag, instr_ack, 1);
        tick();
        instr_valid = 1'b0;
    endtask

    // Row strobe model: a pop at negedge predicts the one-hot strobe seen at the next negedge.
    always @(negedge clk) begin
        if (rst) begin
            if (load_row !== '0) strobe_err++;
            pend  = '0;
            row_m = 0;
        end else begin
            if (load_row !== pend) strobe_err++;
            if (fifo_pop && !fifo_valid) popv_err++;
            if (fifo_pop) begin
                pend    = 32'h8000_0000 >> row_m;
                row_m   = (row_m + 1) % 32;
                pop_cnt++;
            end else begin
                pend = '0;
            end
            if (instr_ack) ack_cnt++;
            if (done) done_cnt++;
        end
    end

    initial begin
        // Reset: outputs quiet even with a load instruction presented.
        instr_valid = 1'b1; instr_load = 1'b1; u_dim = 8'd64; iter_dim = 8'd64; fifo_valid = 1'b1;
        tick();
        check("rst_occ", occupancy, 0);
        check("rst_busy", busy, 0);
        check("rst_rdy", compute_rdy, 0);
        check("rst_row", load_row, 0);
        check("rst_ack", instr_ack, 0);
        check("rst_pop", fifo_pop, 0);
        check("rst_done", done, 0);
        tick();

        // 1: 64x64 job, no consumes -> two tiles fill both buffers, then stall.
        rst = 1'b0;
        #1 check("t1_ack", instr_ack, 1);
        tick();
        instr_valid = 1'b0;
        repeat (80) tick();
        check("t1_pops", pop_cnt, 64);
        check("t1_occ", occupancy, 2);
        check("t1_rdy", compute_rdy, 1);
        check("t1_nopop", fifo_pop, 0);
        check("t1_busy", busy, 1);
        check("t1_rdsel", compute_buf_sel, 0);
        check("t1_wrsel", load_buf_sel, 1);
        check("t1_strobe", strobe_err, 0);

        // 2: four spaced consumes drain the 4-tile job.
        consume = 1'b1; tick(); consume = 1'b0;
        check("t2_occ_c1", occupancy, 1);
        check("t2_rdsel_c1", compute_buf_sel, 1);
        repeat (39) tick();
        check("t2_occ_t3", occupancy, 2);
        check("t2_wrsel_t3", load_buf_sel, 0);
        check("t2_pops_t3", pop_cnt, 96);
        consume = 1'b1; tick(); consume = 1'b0;
        repeat (39) tick();
        check("t2_occ_t4", occupancy, 2);
        check("t2_wrsel_t4", load_buf_sel, 1);
        check("t2_pops_t4", pop_cnt, 128);
        check("t2_nopop", fifo_pop, 0);
        consume = 1'b1; tick(); consume = 1'b0;
        check("t2_occ_c3", occupancy, 1);
        check("t2_done_early", done_cnt, 0);
        repeat (39) tick();
        consume = 1'b1;
        #1 check("t2_done_pulse", done, 1);
        tick(); consume = 1'b0;
        check("t2_done_after", done, 0);
        check("t2_done_cnt", done_cnt, 1);
        check("t2_busy", busy, 0);
        check("t2_occ", occupancy, 0);
        check("t2_acks", ack_cnt, 1);

        // 3: U=40, ITER=33 rounds up to 4 tiles; FIFO valid every other cycle.
        base = pop_cnt; done_base = done_cnt; got_done = 1'b0;
        issue(8'd40, 8'd33, "t3_ack");
        for (int c = 0; c < 3000 && !got_done; c++) begin
            fifo_valid = c[0];
            consume = (occupancy != 0) && (c % 8 == 0);
            #1 if (done) got_done = 1'b1;
            tick();
        end
        consume = 1'b0; fifo_valid = 1'b1;
        check("t3_finished", got_done, 1);
        check("t3_pops", pop_cnt - base, 128);
        check("t3_dones", done_cnt - done_base, 1);
        check("t3_popvalid", popv_err, 0);
        check("t3_strobe", strobe_err, 0);
        check("t3_busy", busy, 0);

        // 4: consume lands on the tile-completing pop while occupancy is 1.
        issue(8'd64, 8'd32, "t4_ack");
        base = pop_cnt;
        for (int c = 0; c < 100; c++) begin
            if (pop_cnt - base == 63) break;
            tick();
        end
        check("t4_sync", pop_cnt - base, 63);
        consume = 1'b1;
        #1 check("t4_pop", fifo_pop, 1);
        check("t4_occ_pre", occupancy, 1);
        check("t4_rdsel_pre", compute_buf_sel, 0);
        tick(); consume = 1'b0;
        check("t4_occ_post", occupancy, 1);
        check("t4_rdsel_post", compute_buf_sel, 1);
        check("t4_wrsel_post", load_buf_sel, 1);
        check("t4_row", load_row, 32'h0000_0001);
        tick();
        consume = 1'b1;
        #1 check("t4_done", done, 1);
        tick(); consume = 1'b0;
        check("t4_busy", busy, 0);
        check("t4_rdsel_wrap", compute_buf_sel, 0);
        // Consume with nothing buffered must change nothing.
        done_base = done_cnt;
        consume = 1'b1;
        #1 check("t4_empty_done", done, 0);
        tick(); consume = 1'b0;
        check("t4_empty_occ", occupancy, 0);
        check("t4_empty_rdsel", compute_buf_sel, 0);
        check("t4_empty_dones", done_cnt - done_base, 0);
        // Non-load instruction is ignored.
        instr_valid = 1'b1; instr_load = 1'b0;
        #1 check("t4_noload_ack", instr_ack, 0);
        tick(); instr_valid = 1'b0;
        check("t4_noload_busy", busy, 0);

        // 5: reset at row 17 of tile 2 abandons the job; next job restarts clean.
        issue(8'd64, 8'd64, "t5_ack");
        base = pop_cnt;
        for (int c = 0; c < 100; c++) begin
            if (pop_cnt - base == 49) break;
            tick();
        end
        check("t5_sync", pop_cnt - base, 49);
        check("t5_row16", load_row, 32'h0000_8000);
        check("t5_wrsel", load_buf_sel, 1);
        check("t5_occ_pre", occupancy, 1);
        rst = 1'b1;
        #1 check("t5_rst_row", load_row, 0);
        check("t5_rst_occ", occupancy, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_rdy", compute_rdy, 0);
        check("t5_rst_wrsel", load_buf_sel, 0);
        check("t5_rst_pop", fifo_pop, 0);
        tick();
        rst = 1'b0;
        issue(8'd32, 8'd32, "t5_ack2");
        tick();
        check("t5_first_row", load_row, 32'h8000_0000);
        check("t5_first_sel", load_buf_sel, 0);
        repeat (40) tick();
        check("t5_occ", occupancy, 1);
        consume = 1'b1;
        #1 check("t5_done", done, 1);
        tick(); consume = 1'b0;
        check("t5_busy", busy, 0);

`ifdef WTS_CHAIN_EN
        // 6: job B accepted while job A drains; each job gets its own done.
        rst = 1'b1; tick(); rst = 1'b0;
        issue(8'd32, 8'd32, "t6_ack_a");
        repeat (40) tick();
        check("t6_occ_a", occupancy, 1);
        check("t6_busy_a", busy, 1);
        issue(8'd32, 8'd32, "t6_ack_b");
        tick();
        check("t6_wrsel_b", load_buf_sel, 1);
        check("t6_row_b", load_row, 32'h8000_0000);
        repeat (40) tick();
        check("t6_occ_b", occupancy, 2);
        consume = 1'b1;
        #1 check("t6_done_a", done, 1);
        tick(); consume = 1'b0;
        check("t6_occ_c1", occupancy, 1);
        check("t6_busy_c1", busy, 1);
        consume = 1'b1;
        #1 check("t6_done_b", done, 1);
        tick(); consume = 1'b0;
        check("t6_busy", busy, 0);
        check("t6_occ", occupancy, 0);
`endif

        check("end_strobe", strobe_err, 0);
        check("end_popvalid", popv_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
